// File: rtl/otter_pipe_ctrl.sv
// otter_pipe_ctrl: pipeline control for the 5-stage OTTER core.
// Tracks per-stage valid bits and a shadow of each in-flight instruction's
// register usage. It produces the stall, flush and bubble controls, the EX
// operand-forwarding selects, the write-back enable and saturating
// stall/flush event counters.
module otter_pipe_ctrl #(
  parameter int ADDR_W = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] DE_RS1,
  input  logic [ADDR_W-1:0] DE_RS2,
  input  logic              DE_RS1_USED,
  input  logic              DE_RS2_USED,
  input  logic [ADDR_W-1:0] DE_RD,
  input  logic              DE_REG_WRITE,
  input  logic              DE_MEM_READ,
  input  logic              DE_MEM_ACCESS,
  input  logic              EX_BRANCH_TAKEN,
  input  logic              MEM_READY,
  input  logic              CNT_CLR,
  output logic              STALL_PC,
  output logic              STALL_IF,
  output logic              STALL_DE,
  output logic              STALL_EX,
  output logic              STALL_MEM,
  output logic              IF_DE_VALID,
  output logic              DE_EX_VALID,
  output logic              EX_MEM_VALID,
  output logic              MEM_WB_VALID,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B,
  output logic              WB_WE,
  output logic              LOAD_USE,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  localparam bit FWD_ON = (FWD_EN != 0);

  // Stage valid bits
  logic r_if_de_vld, r_de_ex_vld, r_ex_mem_vld, r_mem_wb_vld;

  // Shadow of the instruction in EX
  logic [ADDR_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic              r_ex_rs1_used, r_ex_rs2_used;
  logic              r_ex_rw, r_ex_mr, r_ex_ma;

  // Shadow of the instruction in MEM
  logic [ADDR_W-1:0] r_mem_rd;
  logic              r_mem_rw, r_mem_mr, r_mem_ma;

  // Shadow of the instruction in WB
  logic [ADDR_W-1:0] r_wb_rd;
  logic              r_wb_rw;

  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_memstall, w_flush;
  logic w_ex_hit, w_mem_hit;
  logic w_lu_raw, w_raw_ex, w_raw_mem, w_hazard;
  logic w_de_stall;
  logic w_mem_fwd_ok, w_wb_fwd_ok;

  // Saturating increment: sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // MEM result beats WB result; rd==0 and unused sources never forward
  function automatic logic [1:0] fwd_sel(
    input logic              used,
    input logic [ADDR_W-1:0] src,
    input logic              mem_ok,
    input logic [ADDR_W-1:0] mem_rd,
    input logic              wb_ok,
    input logic [ADDR_W-1:0] wb_rd
  );
    if (!used)                      return 2'b00;
    else if (mem_ok && src == mem_rd) return 2'b01;
    else if (wb_ok && src == wb_rd)   return 2'b10;
    else                            return 2'b00;
  endfunction

  // A pending data-memory access in MEM freezes the whole pipe
  assign w_memstall = r_ex_mem_vld & r_mem_ma & ~MEM_READY;
  // Redirect only once EX is free to move; a frozen branch retries on release
  assign w_flush    = r_de_ex_vld & EX_BRANCH_TAKEN & ~w_memstall;

  assign w_ex_hit  = (DE_RS1_USED && DE_RS1 == r_ex_rd) ||
                     (DE_RS2_USED && DE_RS2 == r_ex_rd);
  assign w_mem_hit = (DE_RS1_USED && DE_RS1 == r_mem_rd) ||
                     (DE_RS2_USED && DE_RS2 == r_mem_rd);

  assign w_lu_raw  = r_if_de_vld & r_de_ex_vld & r_ex_mr & (r_ex_rd != '0) & w_ex_hit;
  assign w_raw_ex  = r_if_de_vld & r_de_ex_vld & r_ex_rw & (r_ex_rd != '0) & w_ex_hit;
  assign w_raw_mem = r_if_de_vld & r_ex_mem_vld & r_mem_rw & (r_mem_rd != '0) & w_mem_hit;

  // Without forwarding, any EX/MEM producer blocks DE; the write-first
  // register file already covers a WB producer.
  assign w_hazard   = FWD_ON ? w_lu_raw : (w_raw_ex | w_raw_mem);
  assign w_de_stall = w_hazard & ~w_flush & ~w_memstall;

  assign LOAD_USE  = w_de_stall & w_lu_raw;
  assign STALL_PC  = w_memstall | w_de_stall;
  assign STALL_IF  = w_memstall | w_de_stall;
  assign STALL_DE  = w_memstall | w_de_stall;
  assign STALL_EX  = w_memstall;
  assign STALL_MEM = w_memstall;

  // A load result is not available from MEM, only once it reaches WB
  assign w_mem_fwd_ok = r_ex_mem_vld & r_mem_rw & ~r_mem_mr & (r_mem_rd != '0);
  assign w_wb_fwd_ok  = r_mem_wb_vld & r_wb_rw & (r_wb_rd != '0);

  assign FWD_A = (FWD_ON && r_de_ex_vld) ?
                 fwd_sel(r_ex_rs1_used, r_ex_rs1, w_mem_fwd_ok, r_mem_rd, w_wb_fwd_ok, r_wb_rd) :
                 2'b00;
  assign FWD_B = (FWD_ON && r_de_ex_vld) ?
                 fwd_sel(r_ex_rs2_used, r_ex_rs2, w_mem_fwd_ok, r_mem_rd, w_wb_fwd_ok, r_wb_rd) :
                 2'b00;

  assign WB_WE        = r_mem_wb_vld & r_wb_rw;
  assign IF_DE_VALID  = r_if_de_vld;
  assign DE_EX_VALID  = r_de_ex_vld;
  assign EX_MEM_VALID = r_ex_mem_vld;
  assign MEM_WB_VALID = r_mem_wb_vld;
  assign STALL_CNT    = r_stall_cnt;
  assign FLUSH_CNT    = r_flush_cnt;

  // Advance valid bits and shadow state; memstall freezes, flush/hazard insert bubbles
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_if_de_vld   <= 1'b0;
      r_de_ex_vld   <= 1'b0;
      r_ex_mem_vld  <= 1'b0;
      r_mem_wb_vld  <= 1'b0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_rs1_used <= 1'b0;
      r_ex_rs2_used <= 1'b0;
      r_ex_rw       <= 1'b0;
      r_ex_mr       <= 1'b0;
      r_ex_ma       <= 1'b0;
      r_mem_rd      <= '0;
      r_mem_rw      <= 1'b0;
      r_mem_mr      <= 1'b0;
      r_mem_ma      <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_rw       <= 1'b0;
    end else if (w_memstall) begin
      r_mem_wb_vld  <= 1'b0;
    end else begin
      r_if_de_vld   <= ~w_flush;
      r_de_ex_vld   <= r_if_de_vld & ~w_flush & ~w_de_stall;
      r_ex_mem_vld  <= r_de_ex_vld;
      r_mem_wb_vld  <= r_ex_mem_vld;
      r_ex_rs1      <= DE_RS1;
      r_ex_rs2      <= DE_RS2;
      r_ex_rd       <= DE_RD;
      r_ex_rs1_used <= DE_RS1_USED;
      r_ex_rs2_used <= DE_RS2_USED;
      r_ex_rw       <= DE_REG_WRITE;
      r_ex_mr       <= DE_MEM_READ;
      r_ex_ma       <= DE_MEM_ACCESS;
      r_mem_rd      <= r_ex_rd;
      r_mem_rw      <= r_ex_rw;
      r_mem_mr      <= r_ex_mr;
      r_mem_ma      <= r_ex_ma;
      r_wb_rd       <= r_mem_rd;
      r_wb_rw       <= r_mem_rw;
    end
  end

  // Stall-cycle and flush-event counters; clear wins over increment
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (CNT_CLR) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (STALL_PC) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush)  r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

endmodule

// File: doc/otter_pipe_ctrl.md
Name: otter_pipe_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage OTTER core (IF, DE, EX, MEM, WB).
- Owns the per-stage valid bits.
- Generates stall and flush control for load-use hazards, taken branches/jumps and a variable-latency data memory.
- Drives operand-forwarding selects for the EX-stage ALU, and keeps saturating stall/flush performance counters.

Parameters:
ADDR_W, 5, register-file address width
FWD_EN, 1, 1 = forward from MEM/WB; 0 = no forwarding, stall DE on every RAW hazard
CNT_W, 16, width of STALL_CNT and FLUSH_CNT

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
DE_RS1  in  ADDR_W  rs1 address of DE-stage instruction
DE_RS2  in  ADDR_W  rs2 address of DE-stage instruction
DE_RS1_USED  in  1  DE instruction reads rs1
DE_RS2_USED  in  1  DE instruction reads rs2
DE_RD  in  ADDR_W  destination of DE instruction
DE_REG_WRITE  in  1  DE instruction writes rd
DE_MEM_READ  in  1  DE instruction is a load
DE_MEM_ACCESS  in  1  DE instruction is a load or store
EX_BRANCH_TAKEN  in  1  EX-stage control-flow redirect (jal/jalr/taken branch)
MEM_READY  in  1  data memory completes MEM-stage access this cycle
CNT_CLR  in  1  synchronous clear of both counters
STALL_PC, STALL_IF, STALL_DE, STALL_EX, STALL_MEM  out  1 each  hold stage registers
IF_DE_VALID, DE_EX_VALID, EX_MEM_VALID, MEM_WB_VALID  out  1 each  stage-register valid
FWD_A  out  2  ALU A source: 00 DE/EX register, 01 EX/MEM ALU result, 10 WB data
FWD_B  out  2  same for ALU B / store data
WB_WE  out  1  register-file write enable = MEM_WB_VALID & WB-stage reg_write
LOAD_USE  out  1  load-use stall active this cycle
STALL_CNT  out  CNT_W  cycles with STALL_PC=1
FLUSH_CNT  out  CNT_W  branch flush events

Behaviour:
Reset and tracking:
- RESET_N=0 immediately clears all valid bits, shadow state and counters. All stall outputs are 0, FWD_A/FWD_B=00, WB_WE=0.
- First edge after release sets IF_DE_VALID=1. Remaining valid bits fill one stage per cycle.
- Shadow registers per stage (EX, MEM, WB) hold rs1/rs2/used, rd, reg_write, mem_read, mem_access. They advance with the same stall/bubble rules as the datapath.
- An invalid stage never causes a hazard, forward, write or flush.
- rd==0 never matches anything.

MEM wait (memstall = EX_MEM_VALID & mem_access & !MEM_READY):
- STALL_PC/IF/DE/EX/MEM all 1.
- MEM_WB_VALID next = 0 (bubble into WB).

Load-use (FWD_EN=1):
- Condition: DE_EX_VALID, EX-stage load with rd≠0, and a used DE source equals EX rd.
- LOAD_USE=1; STALL_PC/IF/DE=1; DE_EX_VALID next = 0. EX/MEM continue.
- Exactly one bubble per load; the operand is then forwarded from WB.

Forwarding (FWD_EN=1, combinational from EX shadow state):
- 01 when EX_MEM_VALID, MEM reg_write, not a load, rd≠0 and rd equals the EX source.
- Otherwise 10 when MEM_WB_VALID, WB reg_write, rd≠0 and rd equals the EX source.
- Otherwise 00. MEM beats WB.

FWD_EN=0:
- FWD_A/FWD_B held at 00.
- DE stalls (same effect as load-use) while a valid EX or MEM producer's rd matches a used DE source.
- The register file is write-first, so a WB producer is never a hazard.

Flush (flush = DE_EX_VALID & EX_BRANCH_TAKEN & !memstall):
- Next cycle IF_DE_VALID=0 and DE_EX_VALID=0; PC loads the target (STALL_PC=0).
- FLUSH_CNT +1.

Simultaneous events:
- Flush and load-use: flush wins, the wrong-path DE instruction is discarded, LOAD_USE=0.
- Flush and memstall: memstall wins. EX is frozen, so EX_BRANCH_TAKEN stays asserted and the flush happens on the release cycle.

Counters:
- Saturate at all-ones.
- CNT_CLR has priority over increment.

Latency:
- Stall and forward outputs are combinational from current state and inputs, with no cycle delay.
- Valid bits update on the next edge.

Test Plan:
- Reset, then 6 independent instructions with MEM_READY=1 -> valid bits rise at edges 1..4, no stalls, FWD=00, WB_WE=1 from cycle 4.
- add x5 then add x6,x5 (FWD_EN=1) -> FWD_A=01 in consumer's EX cycle. With one independent instruction between them -> FWD_A=10. With rd=x0 -> 00.
- lw x7 then add x8,x7 -> LOAD_USE=1 for exactly 1 cycle, DE_EX_VALID=0 next, then FWD_A=10, STALL_CNT=1.
- Taken branch in EX -> IF_DE_VALID=DE_EX_VALID=0 next cycle, FLUSH_CNT=1. Same cycle as a load-use hazard -> LOAD_USE=0.
- Store in MEM with MEM_READY=0 for 3 cycles plus branch in EX -> all stalls 1 for 3 cycles, MEM_WB_VALID=0, flush on the 4th cycle, STALL_CNT=3.
- FWD_EN=0: add x5; add x6,x5 -> 2 stall cycles, FWD=00. RESET_N low mid-stall -> all outputs 0 asynchronously. Counter driven to all-ones stays there; CNT_CLR -> 0.
